// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-enabled data RAM with a registered valid/ready load response and a
// post-reset clear sequencer; defining DMEM_PARITY_EN adds per-byte even parity and par_err.
module data_memory_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    input  logic                rsp_ready,
    output logic                busy,
`ifdef DMEM_PARITY_EN
    output logic                par_err,
`endif
    output logic                addr_err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;
    localparam logic STATE_CLEAR = 1'b0;
    localparam logic STATE_RUN = 1'b1;

    logic              state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [IDX_W-1:0]  idx;
    logic              in_range, accept;

    assign idx       = req_addr[IDX_W-1:0];
    assign in_range  = (req_addr >> IDX_W) == '0;
    assign busy      = state_q == STATE_CLEAR;
    assign req_ready = (state_q == STATE_RUN) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign addr_err  = addr_err_q;

    always_comb begin
        state_d     = (busy && clr_cnt_q == IDX_W'(DEPTH - 1)) ? STATE_RUN : state_q;
        clr_cnt_d   = busy ? clr_cnt_q + IDX_W'(1) : clr_cnt_q;
        rd_word     = in_range ? mem_q[idx] : '0;
        rsp_valid_d = accept ? !req_we : rsp_valid_q && !rsp_ready;
        rsp_rdata_d = (accept && !req_we) ? rd_word : rsp_rdata_q;
        addr_err_d  = accept && !in_range;
    end

`ifdef DMEM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] wr_par, rd_par;
    logic          par_err_q, par_err_d;

    assign par_err = par_err_q;

    always_comb begin
        wr_par = '0;
        rd_par = '0;
        for (int i = 0; i < NB; i++) begin
            wr_par[i] = ^req_wdata[8*i +: 8];
            rd_par[i] = ^mem_q[idx][8*i +: 8];
        end
        par_err_d = (accept && !req_we) ? (in_range && rd_par != par_q[idx]) : par_err_q && rsp_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err_q <= 1'b0;
        else        par_err_q <= par_err_d;
    end

    always_ff @(posedge clk) begin
        if (busy) par_q[clr_cnt_q] <= '0;
        else if (accept && req_we && in_range)
            for (int i = 0; i < NB; i++)
                if (req_be[i]) par_q[idx][i] <= wr_par[i];
    end
`endif

    // The array itself is not reset; the clear sequencer zeroes it once reset releases.
    always_ff @(posedge clk) begin
        if (busy) mem_q[clr_cnt_q] <= '0;
        else if (accept && req_we && in_range)
            for (int i = 0; i < NB; i++)
                if (req_be[i]) mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STATE_CLEAR;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_err_q  <= addr_err_d;
        end
    end
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, handshaked data memory for the RISC core's load/store path, generalising the fixed 8-word, 16-bit, combinational-read data RAM. Width and depth are parameters. Writes use per-byte enables. Reads are registered, with a valid/ready response holding register. After every reset a hardware clear sequencer zeroes the array, so the core never reads stale contents.

## Interface
- DATA_W, 16, word width in bits; multiple of 8.
- ADDR_W, 16, width of the request address.
- DEPTH, 8, number of words; power of two, at most 2^ADDR_W.
- IDX_W, $clog2(DEPTH), localparam; array index width.

- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_be  in  DATA_W/8  byte enables; bit i selects bits [8i+7:8i].
- rsp_valid  out  1  load data valid.
- rsp_rdata  out  DATA_W  load data.
- rsp_ready  in  1  consumer takes the response.
- busy  out  1  clear sequence in progress.
- addr_err  out  1  one-cycle pulse on an out-of-range access.
- par_err  out  1  parity error on a load; present only with DMEM_PARITY_EN.

## Operation
- FSM states:
  - CLEAR: entered asynchronously on rst_n low. Writes zero to index clr_cnt each cycle, clr_cnt counting 0..DEPTH-1. Moves to RUN after writing index DEPTH-1.
  - RUN: normal operation.
- Accept condition: a request is accepted when req_valid & req_ready.
- req_ready = (state==RUN) & (!rsp_valid | rsp_ready). It is independent of req_valid.
- In-range test: index = req_addr[IDX_W-1:0]. The access is in range only when req_addr[ADDR_W-1:IDX_W] == 0.
- Store, in range: at the accepting edge, each byte with req_be[i]=1 is updated; the other bytes are unchanged. No response is produced. be=0 is a legal no-op.
- Load, in range: at the accepting edge, rsp_rdata is loaded from the array and rsp_valid is set. The data reflects all previously accepted stores.
- Out of range:
  - Store: dropped.
  - Load: returns rsp_rdata=0 with rsp_valid=1.
  - Both: addr_err = 1 for the cycle after acceptance.
- Response holding: rsp_valid stays high and rsp_rdata stays stable until rsp_ready. If rsp_ready=1 and a new load is accepted in the same cycle, the new response replaces the old one with no bubble. If rsp_ready=1 and nothing is accepted, rsp_valid clears.
- Reset mid-operation: any pending response is discarded. The clear sequence reruns from index 0. Array contents before the clear completes are don't-care.

## Timing
- Reset values: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, addr_err=0, par_err=0, clr_cnt=0.
- Clear: takes exactly DEPTH cycles after rst_n deasserts. busy falls and req_ready rises in the cycle after index DEPTH-1 is written. With DEPTH=8, req_ready is first high on the 9th rising edge after release.
- Load latency: 1 cycle, acceptance edge to rsp_valid.
- Throughput: 1 request per cycle while rsp_ready is held high.
- Store followed by load: a store accepted at edge N is visible to a load accepted at edge N+1.

## Configuration
- DMEM_PARITY_EN defined:
  - One even-parity bit is stored per byte and written with that byte.
  - The clear sequence writes parity 0.
  - On a load, par_err = 1 together with rsp_valid if any byte's parity mismatches; it is held with the response.
  - Out-of-range loads report par_err = 0.
- DMEM_PARITY_EN undefined: no parity storage and no par_err port.

## Test plan
- Reset release, DEPTH=8: busy high for 8 cycles, req_ready=0. Then load addr 5 -> rsp_rdata=0x0000 one cycle later.
- Store 0xBEEF to addr 3 with be=2'b11, then store 0x12xx to addr 3 with be=2'b10, then load addr 3 -> 0x12EF.
- Back-to-back stores then loads: store addr 2, load addr 2 on the next cycle -> new data returned; 4 consecutive loads with rsp_ready=1 -> 4 consecutive rsp_valid cycles.
- Backpressure: load addr 1 with rsp_ready=0 for 3 cycles -> rsp_valid and data held, req_ready=0. rsp_ready=1 -> handshake completes and req_ready returns high.
- Load addr 0x0008 with DEPTH=8 -> rsp_rdata=0 and addr_err pulses 1 cycle. Store 0xAAAA to 0x0008 -> addr 0 still reads its old value.
- Assert rst_n low while a response is pending -> rsp_valid drops immediately. Clear reruns and a prior store to addr 4 reads back 0. With DMEM_PARITY_EN, force a flipped stored bit -> par_err=1 with the response.
